// File: rtl/servo_cmd_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : servo_cmd_uart_tx
// Purpose  : Serialises a 7-bit X and a 7-bit Y servo position as two UART
//            bytes on one line, X byte first. Bit 7 of each byte is the axis
//            tag (0 = X, 1 = Y). 8N1 by default; defining SERVO_TX_PARITY_EN
//            inserts an even-parity bit after each byte's data bits.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            xCmd[6:0]  - X position, sampled on accept
//            yCmd[6:0]  - Y position, sampled on accept
//            sendValid  - request to transmit the current pair
//            sendReady  - a new pair can be accepted
//            txSerial   - UART line, LSB first
//            txBusy     - a frame pair is on the line
//            frameDone  - one-cycle pulse after the Y stop bit
// Options  : SERVO_TX_PARITY_EN - enable even parity (8E1)
// Revision : 1.0 - initial release
// ============================================================================
module servo_cmd_uart_tx #(
    parameter int   CLKS_PER_BIT = 5208,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] xCmd,
    input  logic [6:0] yCmd,
    input  logic       sendValid,
    output logic       sendReady,
    output logic       txSerial,
    output logic       txBusy,
    output logic       frameDone
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERVO_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd3
    } stateType;

    stateType              r_state;
    stateType              w_nextState;
    logic [c_BAUD_W-1:0]   r_baudCnt;
    logic [2:0]            r_bitCnt;
    logic                  r_byteIdx;    // 0 = X byte on the line, 1 = Y byte
    logic [7:0]            r_byte0;
    logic [7:0]            r_byte1;
    logic                  r_frameDone;

    logic                  w_baudLast;
    logic                  w_accept;
    logic [7:0]            w_curByte;

    assign w_baudLast = (r_baudCnt == c_BAUD_LAST);
    assign w_accept   = sendValid && (r_state == S_IDLE);
    assign w_curByte  = r_byteIdx ? r_byte1 : r_byte0;

    assign sendReady  = (r_state == S_IDLE);
    assign txBusy     = (r_state != S_IDLE);
    assign frameDone  = r_frameDone;

    // Next-state and line level
    always_comb begin
        w_nextState = r_state;
        txSerial    = IDLE_LEVEL;
        case (r_state)
            S_IDLE: begin
                if (sendValid) begin
                    w_nextState = S_START;
                end
            end
            S_START: begin
                txSerial = 1'b0;
                if (w_baudLast) begin
                    w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                txSerial = w_curByte[r_bitCnt];
                if (w_baudLast && (r_bitCnt == 3'd7)) begin
`ifdef SERVO_TX_PARITY_EN
                    w_nextState = S_PARITY;
`else
                    w_nextState = S_STOP;
`endif
                end
            end
`ifdef SERVO_TX_PARITY_EN
            S_PARITY: begin
                // Even parity: total count of ones including this bit is even
                txSerial = ^w_curByte;
                if (w_baudLast) begin
                    w_nextState = S_STOP;
                end
            end
`endif
            S_STOP: begin
                txSerial = IDLE_LEVEL;
                if (w_baudLast) begin
                    // Y byte follows X byte with no gap between them
                    w_nextState = r_byteIdx ? S_IDLE : S_START;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_baudCnt   <= '0;
            r_bitCnt    <= 3'd0;
            r_byteIdx   <= 1'b0;
            r_byte0     <= 8'd0;
            r_byte1     <= 8'd0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_frameDone <= (r_state == S_STOP) && w_baudLast && r_byteIdx;

            if (w_accept) begin
                r_byte0   <= {1'b0, xCmd};
                r_byte1   <= {1'b1, yCmd};
                r_byteIdx <= 1'b0;
            end else if ((r_state == S_STOP) && w_baudLast && !r_byteIdx) begin
                r_byteIdx <= 1'b1;
            end

            if ((r_state == S_IDLE) || w_baudLast) begin
                r_baudCnt <= '0;
            end else begin
                r_baudCnt <= r_baudCnt + c_BAUD_W'(1);
            end

            // Advancing past bit 7 returns the counter to 0 for the next byte
            if (r_state == S_IDLE) begin
                r_bitCnt <= 3'd0;
            end else if ((r_state == S_DATA) && w_baudLast) begin
                r_bitCnt <= r_bitCnt + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_cmd_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_servo_cmd_uart_tx
// Purpose  : Directed self-checking bench for servo_cmd_uart_tx with
//            CLKS_PER_BIT=4. Line is sampled at negative edges near bit
//            centres. Honors SERVO_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_cmd_uart_tx;

    localparam int CPB = 4;
`ifdef SERVO_TX_PARITY_EN
    localparam int NB    = 11;
    localparam int FRAME = 88;
`else
    localparam int NB    = 10;
    localparam int FRAME = 80;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] xCmd;
    logic [6:0] yCmd;
    logic       sendValid;
    logic       sendReady;
    logic       txSerial;
    logic       txBusy;
    logic       frameDone;

    int errCount   = 0;
    int checkCount = 0;
    int cyc        = 0;

    servo_cmd_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .IDLE_LEVEL   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .xCmd      (xCmd),
        .yCmd      (yCmd),
        .sendValid (sendValid),
        .sendReady (sendReady),
        .txSerial  (txSerial),
        .txBusy    (txBusy),
        .frameDone (frameDone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request at a negedge; return at the negedge after the accept edge
    task automatic startSend(input logic [6:0] x, input logic [6:0] y, input bit hold);
        @(negedge clk);
        xCmd      = x;
        yCmd      = y;
        sendValid = 1'b1;
        @(negedge clk);
        if (!hold) sendValid = 1'b0;
    endtask

    // Entered at the negedge inside the first start-bit cycle. Returns at the
    // negedge where frameDone is high (or after the bound expires).
    task automatic captureFrame(input logic [7:0] e0, input logic [7:0] e1,
                                input logic p0, input logic p1,
                                input bit perturb, input string tag);
        logic [10:0] fr;
        logic [7:0]  eb [2];
        logic        ep [2];
        int          startCyc;
        int          doneCyc;
        bit          seen;
        eb[0] = e0; eb[1] = e1;
        ep[0] = p0; ep[1] = p1;
        startCyc = cyc;
        checkVal({tag, ".startLat"}, txSerial, 1'b0);
        repeat (2) @(negedge clk);
        checkVal({tag, ".busyReady"}, {txBusy, sendReady}, 2'b10);
        for (int b = 0; b < 2; b++) begin
            fr = '1;
            for (int i = 0; i < NB; i++) begin
                fr[i] = txSerial;
                if (perturb && b == 0 && i == 5) begin
                    xCmd      = 7'h7F;
                    sendValid = 1'b1;
                end
                if (!(b == 1 && i == NB - 1)) begin
                    @(negedge clk);
                    if (perturb) sendValid = 1'b0;
                    repeat (CPB - 1) @(negedge clk);
                end
            end
            checkVal($sformatf("%s.b%0d.start", tag, b), fr[0], 1'b0);
            checkVal($sformatf("%s.b%0d.data", tag, b), fr[8:1], eb[b]);
`ifdef SERVO_TX_PARITY_EN
            checkVal($sformatf("%s.b%0d.parity", tag, b), fr[9], ep[b]);
`endif
            checkVal($sformatf("%s.b%0d.stop", tag, b), fr[NB-1], 1'b1);
        end
        seen = 1'b0;
        doneCyc = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (frameDone) begin
                seen = 1'b1;
                doneCyc = cyc;
            end
        end
        checkVal({tag, ".doneSeen"}, seen, 1'b1);
        checkVal({tag, ".frameLen"}, doneCyc - startCyc, FRAME);
        checkVal({tag, ".readyAtDone"}, sendReady, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst       = 1'b1;
        sendValid = 1'b0;
        xCmd      = 7'h00;
        yCmd      = 7'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst.txSerial", txSerial, 1'b1);
        checkVal("rst.sendReady", sendReady, 1'b1);
        checkVal("rst.txBusy", txBusy, 1'b0);
        checkVal("rst.frameDone", frameDone, 1'b0);
        rst = 1'b0;

        // Idle line with no request
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txSerial !== 1'b1 || txBusy !== 1'b0 || frameDone !== 1'b0) bad++;
        end
        checkVal("idle.line", bad, 0);

        // Single pair: 0x25 then 0xDA, parity 1 for both
        startSend(7'h25, 7'h5A, 1'b0);
        captureFrame(8'h25, 8'hDA, 1'b1, 1'b1, 1'b0, "pair");

        // Inputs changed and sendValid pulsed mid-frame are ignored
        startSend(7'h25, 7'h5A, 1'b0);
        captureFrame(8'h25, 8'hDA, 1'b1, 1'b1, 1'b1, "ignore");
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txBusy !== 1'b0 || txSerial !== 1'b1) bad++;
        end
        checkVal("ignore.noRestart", bad, 0);

        // Back-to-back: sendValid held across frameDone
        startSend(7'h00, 7'h7F, 1'b1);
        captureFrame(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "b2b0");
        @(negedge clk);
        checkVal("b2b.gapBusy", txBusy, 1'b1);
        checkVal("b2b.gapLine", txSerial, 1'b0);
        sendValid = 1'b0;
        captureFrame(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, "b2b1");

        // Reset during byte0 data bit 3
        startSend(7'h25, 7'h5A, 1'b0);
        repeat (17) @(negedge clk);
        checkVal("midRst.preBit3", txSerial, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkVal("midRst.line", txSerial, 1'b1);
        checkVal("midRst.busy", txBusy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkVal("midRst.ready", sendReady, 1'b1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (frameDone !== 1'b0 || txSerial !== 1'b1) bad++;
            @(negedge clk);
        end
        checkVal("midRst.noDone", bad, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
`default_nettype wire
